// File: rtl/gate_response_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : gate_response_checker_if
// Description : Observation and result bundle for the 2-input gate checker.
//               The master side drives the observed gate signals and start;
//               the slave side (the checker) returns status and results.
// Revision    : 1.0 - initial release
// ============================================================================
interface gate_response_checker_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             in_a;
  logic             in_b;
  logic             dut_out;
  logic             busy;
  logic             mismatch;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic [3:0]       coverage;
  logic [1:0]       err_vec;
  logic             done;

  modport master (
    output start, in_a, in_b, dut_out,
    input  busy, mismatch, pass_cnt, fail_cnt, coverage, err_vec, done
  );

  modport slave (
    input  start, in_a, in_b, dut_out,
    output busy, mismatch, pass_cnt, fail_cnt, coverage, err_vec, done
  );
endinterface
`default_nettype wire

// File: rtl/gate_response_checker.sv
`default_nettype none
// ============================================================================
// Module      : gate_response_checker
// Description : Waits for the observed gate inputs to be stable for
//               SETTLE_CYCLES, compares the gate output against the truth
//               table FUNC, and keeps saturating pass/fail counts, the last
//               failing vector and per-vector coverage.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_response_checker #(
  parameter logic [3:0] FUNC          = 4'b0111,
  parameter int         SETTLE_CYCLES = 2,
  parameter int         CNT_W         = 8
) (
  input  wire                     clk,
  input  wire                     rst,
  gate_response_checker_if.slave  chk_if
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_CHECK  = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Settle counter only has to reach SETTLE_CYCLES-1.
  localparam int         C_CW     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  // Value of the counter one cycle before the settle time has elapsed.
  localparam logic [C_CW-1:0] C_PEN = C_CW'(SETTLE_CYCLES - 2);
  localparam logic [CNT_W-1:0] C_MAX = {CNT_W{1'b1}};

  state_t            state_q, state_d;
  logic [1:0]        vec_q, vec_d;
  logic [C_CW-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]  pass_q, pass_d;
  logic [CNT_W-1:0]  fail_q, fail_d;
  logic [3:0]        cov_q, cov_d;
  logic [1:0]        errv_q, errv_d;
  logic              mism_q, mism_d;

  logic [1:0]        w_vec;
  logic              w_chg;
  logic              w_load;
  logic              w_clear;
  logic [3:0]        w_cov_upd;

  assign w_vec     = {chk_if.in_a, chk_if.in_b};
  assign w_chg     = (w_vec != vec_q);
  assign w_cov_upd = cov_q | (4'b0001 << vec_q);

  // Next-state and result logic; a load captures the live vector and restarts settling.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    cov_d   = cov_q;
    errv_d  = errv_q;
    mism_d  = 1'b0;
    w_load  = 1'b0;
    w_clear = 1'b0;

    if (chk_if.start) begin
      // start restarts from any state and discards a pending compare
      w_clear = 1'b1;
      w_load  = 1'b1;
    end else begin
      case (state_q)
        S_SETTLE: begin
          if (w_chg) begin
            w_load = 1'b1;
          end else if (cnt_q == C_PEN) begin
            state_d = S_CHECK;
          end else begin
            cnt_d = cnt_q + C_CW'(1);
          end
        end
        S_CHECK: begin
          if (chk_if.dut_out == FUNC[vec_q]) begin
            if (pass_q != C_MAX) pass_d = pass_q + CNT_W'(1);
          end else begin
            if (fail_q != C_MAX) fail_d = fail_q + CNT_W'(1);
            errv_d = vec_q;
            mism_d = 1'b1;
          end
          cov_d   = w_cov_upd;
          state_d = (w_cov_upd == 4'b1111) ? S_DONE : S_WAIT;
        end
        S_WAIT: begin
          if (w_chg) w_load = 1'b1;
        end
        default: ; // S_IDLE and S_DONE wait for start
      endcase
    end

    if (w_clear) begin
      pass_d = '0;
      fail_d = '0;
      cov_d  = '0;
      errv_d = '0;
    end
    if (w_load) begin
      vec_d   = w_vec;
      cnt_d   = '0;
      // A one-cycle settle time means the capture edge itself completes settling.
      state_d = (SETTLE_CYCLES == 1) ? S_CHECK : S_SETTLE;
    end
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      pass_q  <= '0;
      fail_q  <= '0;
      cov_q   <= '0;
      errv_q  <= '0;
      mism_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      cov_q   <= cov_d;
      errv_q  <= errv_d;
      mism_q  <= mism_d;
    end
  end

  assign chk_if.busy     = (state_q == S_SETTLE) || (state_q == S_CHECK) || (state_q == S_WAIT);
  assign chk_if.done     = (state_q == S_DONE);
  assign chk_if.mismatch = mism_q;
  assign chk_if.pass_cnt = pass_q;
  assign chk_if.fail_cnt = fail_q;
  assign chk_if.coverage = cov_q;
  assign chk_if.err_vec  = errv_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_response_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_response_checker
// Description : Scoreboard bench for gate_response_checker. Directed vectors
//               with hand-computed outcomes are queued as they are applied; a
//               monitor pops one entry per observed compare.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_response_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gate_response_checker_if #(.CNT_W(8)) if0 ();
  gate_response_checker_if #(.CNT_W(8)) if1 ();
  gate_response_checker_if #(.CNT_W(2)) if2 ();

  logic stuck0 = 1'b0;

  // Gate models: ideal NAND, optionally stuck at 1 for the main instance.
  assign if0.dut_out = stuck0 | ~(if0.in_a & if0.in_b);
  assign if1.dut_out = ~(if1.in_a & if1.in_b);
  assign if2.dut_out = ~(if2.in_a & if2.in_b);

  gate_response_checker #(.FUNC(4'b0111), .SETTLE_CYCLES(2), .CNT_W(8))
    u0 (.clk(clk), .rst(rst), .chk_if(if0));
  gate_response_checker #(.FUNC(4'b0111), .SETTLE_CYCLES(3), .CNT_W(8))
    u1 (.clk(clk), .rst(rst), .chk_if(if1));
  gate_response_checker #(.FUNC(4'b0111), .SETTLE_CYCLES(2), .CNT_W(2))
    u2 (.clk(clk), .rst(rst), .chk_if(if2));

  int checks = 0;
  int errors = 0;

  // Scoreboard entry: {expected_fail, vector}
  logic [2:0] sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Apply a vector to u0 and hold it; queue the expected compare if one is due.
  task automatic apply0(input logic [1:0] v, input bit push, input bit fail, input int hold);
    {if0.in_a, if0.in_b} = v;
    if (push) sb.push_back({fail, v});
    step(hold);
  endtask

  task automatic start0(input logic [1:0] v, input bit push, input bit fail);
    {if0.in_a, if0.in_b} = v;
    if0.start = 1'b1;
    if (push) sb.push_back({fail, v});
    step(1);
    if0.start = 1'b0;
    step(3);
  endtask

  // Monitor on u0: a counter step marks a compare; pop and check its outcome.
  logic [7:0] prev_p, prev_f;
  always @(negedge clk) begin
    logic inc_p, inc_f;
    logic [2:0] e;
    inc_p = (if0.pass_cnt == prev_p + 8'd1);
    inc_f = (if0.fail_cnt == prev_f + 8'd1);
    if (!rst) begin
      chk("busy_done_excl", {31'd0, if0.busy & if0.done}, 32'd0);
      if (inc_p || inc_f) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_compare: pass %0d fail %0d with empty queue at %0t",
                   if0.pass_cnt, if0.fail_cnt, $time);
        end else begin
          e = sb.pop_front();
          chk("cmp_fail_flag", {31'd0, inc_f}, {31'd0, e[2]});
          chk("mismatch_pulse", {31'd0, if0.mismatch}, {31'd0, e[2]});
          chk("cov_bit", {31'd0, if0.coverage[e[1:0]]}, 32'd1);
          if (e[2]) chk("err_vec", {30'd0, if0.err_vec}, {30'd0, e[1:0]});
        end
      end else begin
        chk("mismatch_idle", {31'd0, if0.mismatch}, 32'd0);
      end
    end
    prev_p = if0.pass_cnt;
    prev_f = if0.fail_cnt;
  end

  initial begin
    if0.start = 1'b0; if0.in_a = 1'b0; if0.in_b = 1'b0;
    if1.start = 1'b0; if1.in_a = 1'b0; if1.in_b = 1'b0;
    if2.start = 1'b0; if2.in_a = 1'b0; if2.in_b = 1'b0;

    // Reset state
    step(3);
    chk("rst_pass",  {24'd0, if0.pass_cnt}, 32'd0);
    chk("rst_fail",  {24'd0, if0.fail_cnt}, 32'd0);
    chk("rst_cov",   {28'd0, if0.coverage}, 32'd0);
    chk("rst_errv",  {30'd0, if0.err_vec},  32'd0);
    chk("rst_busy",  {31'd0, if0.busy},     32'd0);
    chk("rst_done",  {31'd0, if0.done},     32'd0);
    chk("rst_mism",  {31'd0, if0.mismatch}, 32'd0);
    rst = 1'b0;
    step(2);
    chk("idle_busy", {31'd0, if0.busy}, 32'd0);

    // T1: ideal NAND sweep
    start0(2'b00, 1'b1, 1'b0);
    apply0(2'b01, 1'b1, 1'b0, 4);
    apply0(2'b10, 1'b1, 1'b0, 4);
    apply0(2'b11, 1'b1, 1'b0, 4);
    chk("t1_pass", {24'd0, if0.pass_cnt}, 32'd4);
    chk("t1_fail", {24'd0, if0.fail_cnt}, 32'd0);
    chk("t1_cov",  {28'd0, if0.coverage}, 32'hF);
    chk("t1_done", {31'd0, if0.done},     32'd1);
    chk("t1_busy", {31'd0, if0.busy},     32'd0);

    // T2: output stuck at 1 -> only vector 11 fails
    stuck0 = 1'b1;
    start0(2'b00, 1'b1, 1'b0);
    apply0(2'b01, 1'b1, 1'b0, 4);
    apply0(2'b10, 1'b1, 1'b0, 4);
    apply0(2'b11, 1'b1, 1'b1, 4);
    chk("t2_pass", {24'd0, if0.pass_cnt}, 32'd3);
    chk("t2_fail", {24'd0, if0.fail_cnt}, 32'd1);
    chk("t2_errv", {30'd0, if0.err_vec},  32'd3);
    chk("t2_done", {31'd0, if0.done},     32'd1);
    // DONE ignores input changes
    apply0(2'b01, 1'b0, 1'b0, 4);
    chk("t2_hold_pass", {24'd0, if0.pass_cnt}, 32'd3);

    // T6: start from DONE clears results on the next cycle
    stuck0 = 1'b0;
    {if0.in_a, if0.in_b} = 2'b00;
    if0.start = 1'b1;
    sb.push_back({1'b0, 2'b00});
    step(1);
    if0.start = 1'b0;
    chk("t6_pass", {24'd0, if0.pass_cnt}, 32'd0);
    chk("t6_fail", {24'd0, if0.fail_cnt}, 32'd0);
    chk("t6_cov",  {28'd0, if0.coverage}, 32'd0);
    chk("t6_errv", {30'd0, if0.err_vec},  32'd0);
    chk("t6_busy", {31'd0, if0.busy},     32'd1);
    chk("t6_done", {31'd0, if0.done},     32'd0);
    step(3);

    // T5: reset in the middle of SETTLE aborts the pending compare
    apply0(2'b01, 1'b0, 1'b0, 1);
    rst = 1'b1;
    step(1);
    chk("t5_rst_pass", {24'd0, if0.pass_cnt}, 32'd0);
    chk("t5_rst_cov",  {28'd0, if0.coverage}, 32'd0);
    chk("t5_rst_busy", {31'd0, if0.busy},     32'd0);
    chk("t5_rst_done", {31'd0, if0.done},     32'd0);
    step(1);
    rst = 1'b0;
    apply0(2'b10, 1'b0, 1'b0, 3);
    chk("t5_idle_busy", {31'd0, if0.busy},     32'd0);
    chk("t5_idle_pass", {24'd0, if0.pass_cnt}, 32'd0);
    start0(2'b11, 1'b1, 1'b0);
    chk("t5_pass", {24'd0, if0.pass_cnt}, 32'd1);
    chk("t5_fail", {24'd0, if0.fail_cnt}, 32'd0);
    chk("t5_cov",  {28'd0, if0.coverage}, 32'h8);

    // T3: glitch restarts the settle window (SETTLE_CYCLES=3)
    {if1.in_a, if1.in_b} = 2'b01;
    if1.start = 1'b1;
    step(1);
    if1.start = 1'b0;
    {if1.in_a, if1.in_b} = 2'b10;
    step(1);                        // switch sampled here
    step(1);
    chk("t3_pass_k2", {24'd0, if1.pass_cnt}, 32'd0);
    step(1);
    chk("t3_pass_k3", {24'd0, if1.pass_cnt}, 32'd0);
    step(1);
    chk("t3_pass_k4", {24'd0, if1.pass_cnt}, 32'd1);
    chk("t3_cov",     {28'd0, if1.coverage}, 32'h4);
    step(4);
    chk("t3_pass_end", {24'd0, if1.pass_cnt}, 32'd1);
    chk("t3_fail_end", {24'd0, if1.fail_cnt}, 32'd0);

    // T4: 2-bit counters saturate after 3 passes
    {if2.in_a, if2.in_b} = 2'b00;
    if2.start = 1'b1;
    step(1);
    if2.start = 1'b0;
    step(3);
    for (int i = 1; i < 10; i++) begin
      {if2.in_a, if2.in_b} = (i % 2 == 1) ? 2'b01 : 2'b00;
      step(4);
      if (i == 2) chk("t4_pass_3", {30'd0, if2.pass_cnt}, 32'd3);
    end
    chk("t4_pass_sat", {30'd0, if2.pass_cnt}, 32'd3);
    chk("t4_fail",     {30'd0, if2.fail_cnt}, 32'd0);
    chk("t4_cov",      {28'd0, if2.coverage}, 32'h3);
    chk("t4_done",     {31'd0, if2.done},     32'd0);

    step(2);
    chk("sb_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
